fetch_stage: RTL and testbench

//  Instruction-fetch stage directly upstream of the decoder. Holds the PC, issues one

---
 rtl/arm_pkg.sv | 19 +
 rtl/branch_target_calc.sv | 20 ++
 rtl/fetch_stage.sv | 165 ++++++++++++++++
 tb/tb_fetch_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-style front end: fetch FSM encoding,
// pipeline constants and the branch-offset sign extension helper.
package arm_pkg;

  localparam int INSTR_W     = 32;
  localparam int PC_STEP     = 4;
  localparam int PIPE_OFFSET = 8;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sext24to32(input logic [23:0] i_val);
    return {{8{i_val[23]}}, i_val};
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch address generation: PC-relative word offset with the
// +8 pipeline bias, plus the BL return address.
module branch_target_calc
  import arm_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_branch_pc,
  input  logic [23:0]       i_branch_imm,
  output logic [ADDR_W-1:0] o_target,
  output logic [ADDR_W-1:0] o_link_addr
);

  logic [31:0] w_byte_off;

  assign w_byte_off  = sext24to32(i_branch_imm) << 2;
  assign o_target    = i_branch_pc + ADDR_W'(PIPE_OFFSET) + ADDR_W'(w_byte_off);
  assign o_link_addr = i_branch_pc + ADDR_W'(PC_STEP);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single outstanding memory read, one-entry skid buffer
// behind the decode-facing output register, branch redirect and BL link write.
module fetch_stage
  import arm_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_pc,
  input  logic [23:0]        branch_imm,
  input  logic               branch_link,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               link_we,
  output logic [ADDR_W-1:0]  link_data
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_discard;
  logic [INSTR_W-1:0] r_skid_data;
  logic [ADDR_W-1:0]  r_skid_pc;
  logic [INSTR_W-1:0] r_instruction;
  logic               r_instr_valid;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_link_we;
  logic [ADDR_W-1:0]  r_link_data;
  logic [ADDR_W-1:0]  w_target;
  logic [ADDR_W-1:0]  w_link_addr;
  logic               w_out_free;
  logic               w_consume;

  branch_target_calc #(.ADDR_W(ADDR_W)) u_btc (
    .i_branch_pc (branch_pc),
    .i_branch_imm(branch_imm),
    .o_target    (w_target),
    .o_link_addr (w_link_addr)
  );

  assign w_out_free = !r_instr_valid || !stall;
  assign w_consume  = r_instr_valid && !stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A branch only changes the FSM path in WAIT/HOLD; in FETCH the handshake still decides.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: begin
        if (imem_ready) w_state_nxt = ST_WAIT;
        else            w_state_nxt = ST_FETCH;
      end
      ST_WAIT: begin
        if (!imem_rvalid) begin
          w_state_nxt = ST_WAIT;
        end else if (branch_taken || r_discard || w_out_free) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (branch_taken || !stall) w_state_nxt = ST_FETCH;
        else                        w_state_nxt = ST_HOLD;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    if (reset && (r_state == ST_FETCH)) imem_req = 1'b1;
    else                                imem_req = 1'b0;
  end

  assign imem_addr = r_pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_discard     <= 1'b0;
      r_skid_data   <= '0;
      r_skid_pc     <= '0;
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_instr_pc    <= '0;
      r_link_we     <= 1'b0;
      r_link_data   <= '0;
    end else begin
      r_link_we <= 1'b0;
      if (branch_taken) begin
        // Flush: the skid empties implicitly because the FSM leaves HOLD.
        r_pc          <= w_target;
        r_instr_valid <= 1'b0;
        if ((r_state == ST_FETCH) && imem_ready) begin
          r_discard <= 1'b1;
        end else if ((r_state == ST_WAIT) && !imem_rvalid) begin
          r_discard <= 1'b1;
        end else begin
          r_discard <= 1'b0;
        end
        if (branch_link) begin
          r_link_we   <= 1'b1;
          r_link_data <= w_link_addr;
        end
      end else begin
        if (w_consume) begin
          r_instr_valid <= 1'b0;
        end
        case (r_state)
          ST_WAIT: begin
            if (imem_rvalid) begin
              if (r_discard) begin
                r_discard <= 1'b0;
              end else if (w_out_free) begin
                r_instruction <= imem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
                r_pc          <= r_pc + ADDR_W'(PC_STEP);
              end else begin
                r_skid_data <= imem_rdata;
                r_skid_pc   <= r_pc;
                r_pc        <= r_pc + ADDR_W'(PC_STEP);
              end
            end
          end
          ST_HOLD: begin
            if (!stall) begin
              r_instruction <= r_skid_data;
              r_instr_pc    <= r_skid_pc;
              r_instr_valid <= 1'b1;
            end
          end
          default: begin
            r_discard <= r_discard;
          end
        endcase
      end
    end
  end

  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign instr_pc    = r_instr_pc;
  assign link_we     = r_link_we;
  assign link_data   = r_link_data;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: transaction-level model (word queue
// in front of decode, one outstanding read), directed scenarios, then random traffic.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [23:0] branch_imm;
  logic        branch_link;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        link_we;
  logic [31:0] link_data;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_pc(branch_pc),
    .branch_imm(branch_imm), .branch_link(branch_link),
    .instruction(instruction), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .link_we(link_we), .link_data(link_data)
  );

  int total = 0;
  int bad   = 0;

  // Model: words waiting for decode (front = presented), at most one read in flight.
  logic [63:0] q[$];
  bit          m_out, m_stale, m_lwe;
  logic [31:0] m_pc, m_instr, m_ipc, m_ldata;

  // Memory environment
  bit          mem_pend;
  int          mem_dly;
  logic [31:0] mem_addr;
  int          mem_lat = 1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  bit          late_rv = 1'b0;
  logic [31:0] hs_log[$];
  logic [31:0] cons_log[$];
  bit          saw_beef;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_target(input logic [31:0] bpc, input logic [23:0] imm);
    longint off;
    off = longint'(imm);
    if (off >= 64'sd8388608) off = off - 64'sd16777216;
    return bpc + 32'd8 + 32'(off * 4);
  endfunction

  task automatic model_update();
    bit req, hs;
    if (!reset) begin
      q.delete();
      m_out = 1'b0; m_stale = 1'b0; m_lwe = 1'b0;
      m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_ldata = 32'h0;
    end else begin
      req   = !m_out && (q.size() < 2);
      hs    = req && imem_ready;
      m_lwe = 1'b0;
      if (branch_taken) begin
        if (m_out) begin
          if (imem_rvalid) begin m_out = 1'b0; m_stale = 1'b0; end
          else m_stale = 1'b1;
        end else if (hs) begin
          m_out = 1'b1; m_stale = 1'b1;
        end
        q.delete();
        m_pc = model_target(branch_pc, branch_imm);
        if (branch_link) begin m_lwe = 1'b1; m_ldata = branch_pc + 32'd4; end
      end else begin
        if (q.size() > 0 && !stall) void'(q.pop_front());
        if (m_out && imem_rvalid) begin
          if (!m_stale) begin
            q.push_back({imem_rdata, m_pc});
            m_pc = m_pc + 32'd4;
          end
          m_out = 1'b0; m_stale = 1'b0;
        end else if (hs) begin
          m_out = 1'b1;
        end
      end
      if (q.size() > 0) begin
        m_instr = q[0][63:32];
        m_ipc   = q[0][31:0];
      end
    end
  endtask

  task automatic compare();
    bit exp_req;
    exp_req = (reset === 1'b1) && !m_out && (q.size() < 2);
    chk("imem_req",    32'(imem_req),    32'(exp_req));
    chk("imem_addr",   imem_addr,        m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
    chk("instruction", instruction,      m_instr);
    chk("instr_pc",    instr_pc,         m_ipc);
    chk("link_we",     32'(link_we),     32'(m_lwe));
    chk("link_data",   link_data,        m_ldata);
    if (instruction === 32'hDEADBEEF) saw_beef = 1'b1;
  endtask

  // One clock: drive memory response, capture handshake, update model, compare.
  task automatic cyc();
    bit          rv, hs;
    logic [31:0] a;
    rv = 1'b0;
    if (late_rv) begin
      rv = 1'b1; imem_rdata = ovr_data; late_rv = 1'b0;
    end else if (mem_pend && mem_dly == 0) begin
      rv = 1'b1;
      imem_rdata = ovr_en ? ovr_data : (mem_addr | 32'hE0000000);
    end else begin
      imem_rdata = $urandom;
    end
    imem_rvalid = rv;
    #1;
    hs = imem_req && imem_ready;
    a  = imem_addr;
    if (reset && instr_valid && !stall && !branch_taken) cons_log.push_back(instr_pc);
    @(posedge clk);
    model_update();
    if (rv) mem_pend = 1'b0;
    else if (mem_pend) mem_dly--;
    if (hs) begin
      mem_pend = 1'b1; mem_dly = mem_lat - 1; mem_addr = a;
      hs_log.push_back(a);
    end
    if (!reset) mem_pend = 1'b0;
    @(negedge clk);
    branch_taken = 1'b0;
    imem_rvalid  = 1'b0;
    compare();
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 40 && hs_log.size() < n; i++) cyc();
  endtask

  task automatic chk_hs(input string name, input int idx, input logic [31:0] exp);
    if (hs_log.size() > idx) chk(name, hs_log[idx], exp);
    else chk({name, "_missing"}, 32'(hs_log.size()), 32'(idx + 1));
  endtask

  task automatic chk_cons(input string name, input int idx, input logic [31:0] exp);
    if (cons_log.size() > idx) chk(name, cons_log[idx], exp);
    else chk({name, "_missing"}, 32'(cons_log.size()), 32'(idx + 1));
  endtask

  task automatic do_branch(input logic [31:0] bpc, input logic [23:0] imm, input bit lnk);
    branch_taken = 1'b1; branch_pc = bpc; branch_imm = imm; branch_link = lnk;
    cyc();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(imem_req),    32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instruction,      32'd0);
    chk({tag, "_ipc"},   instr_pc,         32'd0);
    chk({tag, "_lwe"},   32'(link_we),     32'd0);
    chk({tag, "_ldata"}, link_data,        32'd0);
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; branch_taken = 1'b0; branch_pc = 32'h0; branch_imm = 24'h0; branch_link = 1'b0;
    mem_pend = 1'b0; mem_dly = 0; mem_addr = 32'h0; saw_beef = 1'b0;
    @(negedge clk);
    cyc(); cyc();
    chk_all_zero("reset");

    // Model pins
    chk("model_tgt_back", model_target(32'h10, 24'hFFFFFE), 32'h10);
    chk("model_tgt_fwd",  model_target(32'h10, 24'h000003), 32'h24);

    // Streaming fetch with a 3-cycle stall that pushes a word into the skid
    reset = 1'b1; imem_ready = 1'b1; mem_lat = 1;
    hs_log.delete(); cons_log.delete();
    for (int i = 0; i < 20; i++) begin
      stall = (i >= 4 && i < 7);
      cyc();
    end
    chk_hs("t1_addr0", 0, 32'h0);
    chk_hs("t1_addr1", 1, 32'h4);
    chk_hs("t1_addr2", 2, 32'h8);
    chk_cons("t2_cons0", 0, 32'h0);
    chk_cons("t2_cons1", 1, 32'h4);
    chk_cons("t2_cons2", 2, 32'h8);
    chk_cons("t2_cons3", 3, 32'hC);

    // Plain branch backwards to 0x10
    stall = 1'b0;
    do_branch(32'h10, 24'hFFFFFE, 1'b0);
    chk("t3_valid_drop", 32'(instr_valid), 32'd0);
    chk("t3_no_link",    32'(link_we),     32'd0);
    hs_log.delete();
    wait_hs(1);
    chk_hs("t3_target", 0, 32'h10);

    // BL forward
    do_branch(32'h10, 24'h000003, 1'b1);
    chk("t4_link_we",   32'(link_we), 32'd1);
    chk("t4_link_data", link_data,    32'h14);
    hs_log.delete();
    cyc();
    chk("t4_link_pulse", 32'(link_we), 32'd0);
    wait_hs(1);
    chk_hs("t4_target", 0, 32'h24);

    // Branch while WAIT; stale DEADBEEF arrives two cycles later
    imem_ready = 1'b0; mem_lat = 3;
    for (int i = 0; i < 4; i++) cyc();
    imem_ready = 1'b1;
    for (int i = 0; i < 20 && !m_out; i++) cyc();
    chk("t5_in_wait", 32'(m_out), 32'd1);
    saw_beef = 1'b0; ovr_en = 1'b1; ovr_data = 32'hDEADBEEF;
    do_branch(32'h100, 24'h0, 1'b0);
    hs_log.delete();
    for (int i = 0; i < 10 && mem_pend; i++) cyc();
    ovr_en = 1'b0; mem_lat = 1;
    wait_hs(1);
    chk_hs("t5_target", 0, 32'h108);
    for (int i = 0; i < 6; i++) cyc();
    chk("t5_no_beef", 32'(saw_beef), 32'd0);

    // Reset while WAIT, then a late rvalid
    mem_lat = 3;
    for (int i = 0; i < 20 && !m_out; i++) cyc();
    reset = 1'b0;
    cyc();
    chk_all_zero("t6w");
    reset = 1'b1; imem_ready = 1'b0; late_rv = 1'b1; ovr_data = 32'hDEADBEEF;
    cyc(); cyc();
    chk("t6_late_ignored", 32'(instr_valid), 32'd0);
    imem_ready = 1'b1; mem_lat = 1;
    hs_log.delete();
    wait_hs(1);
    chk_hs("t6_restart", 0, 32'h0);

    // Reset while HOLD
    stall = 1'b1;
    for (int i = 0; i < 30 && q.size() < 2; i++) cyc();
    chk("t6_in_hold", 32'(q.size()), 32'd2);
    reset = 1'b0;
    cyc();
    chk_all_zero("t6h");
    reset = 1'b1; stall = 1'b0;

    // PC wrap through the top of the address space
    cyc(); cyc();
    do_branch(32'hFFFFFFF4, 24'h0, 1'b1);
    chk("wrap_link", link_data, 32'hFFFFFFF8);
    hs_log.delete();
    wait_hs(2);
    chk_hs("wrap_a0", 0, 32'hFFFFFFFC);
    chk_hs("wrap_a1", 1, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      imem_ready   = ($urandom_range(99) < 70);
      stall        = ($urandom_range(99) < 30);
      branch_taken = ($urandom_range(99) < 6);
      branch_link  = 1'($urandom_range(1));
      branch_pc    = $urandom;
      branch_imm   = 24'($urandom);
      reset        = ($urandom_range(199) != 0);
      mem_lat      = $urandom_range(3, 1);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
